// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the four-digit BCD entry block.
// Command priority is encoded in cmd_t order: higher value wins.
package digit_entry_pkg;

    localparam int         DIGITS  = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EDIT,
        ST_COMMIT
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_DEC,
        CMD_INC,
        CMD_SEL,
        CMD_LOAD
    } cmd_t;

    function automatic cmd_t pick_cmd(
        input logic load,
        input logic sel,
        input logic inc,
        input logic dec
    );
        if (load) return CMD_LOAD;
        if (sel)  return CMD_SEL;
        if (inc)  return CMD_INC;
        if (dec)  return CMD_DEC;
        return CMD_NONE;
    endfunction

    function automatic logic [3:0] bcd_step(
        input logic [3:0] d,
        input logic       up
    );
        if (up) return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
        return (d == 4'd0 || d > BCD_MAX) ? BCD_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/digit_entry_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter and
// one-cycle registered pulse on each accepted press.
module button_debounce #(
    parameter int DB_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_press
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic          r_db_q;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_db    <= 1'b0;
            r_db_q  <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_db_q  <= r_db;
            r_pulse <= r_db & ~r_db_q;
            // Any return to the accepted level restarts the stability count
            if (r_s2 != r_db) begin
                if (r_cnt == CW'(DB_CYCLES - 1)) begin
                    r_db  <= ~r_db;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_pulse;

endmodule

// File: rtl/digit_entry.sv
// Four-digit BCD entry: select/increment/decrement/load buttons drive
// an IDLE/EDIT/COMMIT FSM with a blinking selected digit.
module digit_entry #(
    parameter int DB_CYCLES    = 250000,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       CE,
    input  logic       BTN_SEL,
    input  logic       BTN_INC,
    input  logic       BTN_DEC,
    input  logic       BTN_LOAD,
    output logic [3:0] W,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic [3:0] Z,
    output logic [3:0] DP,
    output logic [3:0] BLANK,
    output logic       LOAD_VALID,
    output logic       EDITING
);

    import digit_entry_pkg::*;

    localparam int BW = $clog2(BLINK_CYCLES + 1);

    logic                   w_p_sel;
    logic                   w_p_inc;
    logic                   w_p_dec;
    logic                   w_p_load;
    cmd_t                   w_cmd;

    state_t                 r_state;
    state_t                 w_state_n;
    logic [1:0]             r_sel;
    logic [1:0]             w_sel_n;
    logic [DIGITS-1:0][3:0] r_dig;
    logic [DIGITS-1:0][3:0] w_dig_n;
    logic [BW-1:0]          r_bcnt;
    logic [BW-1:0]          w_bcnt_n;
    logic                   r_phase;
    logic                   w_phase_n;

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
        .i_clk(CLK), .i_rst(R), .i_raw(BTN_SEL), .o_press(w_p_sel)
    );
    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .i_clk(CLK), .i_rst(R), .i_raw(BTN_INC), .o_press(w_p_inc)
    );
    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dec (
        .i_clk(CLK), .i_rst(R), .i_raw(BTN_DEC), .o_press(w_p_dec)
    );
    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
        .i_clk(CLK), .i_rst(R), .i_raw(BTN_LOAD), .o_press(w_p_load)
    );

    assign w_cmd = CE ? pick_cmd(w_p_load, w_p_sel, w_p_inc, w_p_dec)
                      : CMD_NONE;

    always_ff @(posedge CLK) begin
        if (R) begin
            r_state <= ST_IDLE;
            r_sel   <= 2'd0;
            r_dig   <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_sel   <= w_sel_n;
            r_dig   <= w_dig_n;
            r_bcnt  <= w_bcnt_n;
            r_phase <= w_phase_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_sel_n   = r_sel;
        w_dig_n   = r_dig;
        w_bcnt_n  = '0;
        w_phase_n = 1'b0;
        if (r_state == ST_EDIT) begin
            w_phase_n = r_phase;
            if (r_bcnt == BW'(BLINK_CYCLES - 1)) begin
                w_phase_n = ~r_phase;
            end else begin
                w_bcnt_n = r_bcnt + 1'b1;
            end
        end
        unique case (r_state)
            ST_IDLE: begin
                if (w_cmd == CMD_LOAD) begin
                    w_state_n = ST_COMMIT;
                end else if (w_cmd == CMD_SEL) begin
                    w_state_n = ST_EDIT;
                    w_sel_n   = 2'd0;
                end
            end
            ST_EDIT: begin
                // Edits restart the blink so the touched digit shows at once
                unique case (w_cmd)
                    CMD_LOAD: w_state_n = ST_COMMIT;
                    CMD_SEL: begin
                        w_sel_n   = r_sel + 2'd1;
                        w_bcnt_n  = '0;
                        w_phase_n = 1'b0;
                    end
                    CMD_INC, CMD_DEC: begin
                        w_dig_n[r_sel] = bcd_step(r_dig[r_sel],
                                                  w_cmd == CMD_INC);
                        w_bcnt_n  = '0;
                        w_phase_n = 1'b0;
                    end
                    default: ;
                endcase
            end
            ST_COMMIT: begin
                w_state_n = ST_IDLE;
                w_sel_n   = 2'd0;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    assign W          = r_dig[3];
    assign X          = r_dig[2];
    assign Y          = r_dig[1];
    assign Z          = r_dig[0];
    assign EDITING    = (r_state == ST_EDIT);
    assign LOAD_VALID = (r_state == ST_COMMIT);
    assign DP         = EDITING ? (4'b0001 << r_sel) : 4'b0000;
    assign BLANK      = (EDITING && r_phase) ? (4'b0001 << r_sel) : 4'b0000;

endmodule

// File: tb/tb_digit_entry.sv
// Self-checking bench for digit_entry with randomized button sequences
// checked against a press-level behavioural model.
module tb_digit_entry;

    logic       CLK = 1'b0;
    logic       R = 1'b1;
    logic       CE = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic [3:0] W, X, Y, Z, DP, BLANK;
    logic       LOAD_VALID, EDITING;

    int n_cmp = 0;
    int n_fail = 0;

    int m_dig[4];
    int m_sel;
    bit m_edit;

    int         lv_cnt = 0;
    logic [15:0] lv_val;

    digit_entry #(.DB_CYCLES(4), .BLINK_CYCLES(8)) dut (
        .CLK(CLK), .R(R), .CE(CE),
        .BTN_SEL(btn[0]), .BTN_INC(btn[1]),
        .BTN_DEC(btn[2]), .BTN_LOAD(btn[3]),
        .W(W), .X(X), .Y(Y), .Z(Z),
        .DP(DP), .BLANK(BLANK),
        .LOAD_VALID(LOAD_VALID), .EDITING(EDITING)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (LOAD_VALID === 1'b1) begin
            lv_cnt++;
            lv_val = {W, X, Y, Z};
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] m_val();
        return {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
    endfunction

    function automatic logic [3:0] m_dp();
        return m_edit ? 4'(1 << m_sel) : 4'b0000;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_sel = 0;
        m_edit = 0;
    endtask

    // b: 0 select, 1 increment, 2 decrement, 3 load
    task automatic apply(input int b);
        case (b)
            0: begin
                if (!m_edit) begin
                    m_edit = 1;
                    m_sel = 0;
                end else begin
                    m_sel = (m_sel + 1) % 4;
                end
            end
            1: if (m_edit) m_dig[m_sel] = (m_dig[m_sel] + 1) % 10;
            2: if (m_edit) m_dig[m_sel] = (m_dig[m_sel] + 9) % 10;
            default: begin
                m_edit = 0;
                m_sel = 0;
            end
        endcase
    endtask

    task automatic press(input int b, input int hold, input int gap);
        btn[b] = 1'b1;
        repeat (hold) tick();
        btn[b] = 1'b0;
        repeat (gap) tick();
        if (CE) apply(b);
    endtask

    task automatic test_reset();
        R = 1'b1;
        repeat (3) tick();
        R = 1'b0;
        m_reset();
        for (int i = 0; i < 50; i++) begin
            tick();
            n_cmp++;
            if ({W, X, Y, Z, DP, BLANK, LOAD_VALID, EDITING} !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %h exp 0", i,
                         {W, X, Y, Z, DP, BLANK, LOAD_VALID, EDITING});
            end
        end
        n_cmp++;
        if (lv_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_no_load: got %0d exp 0", lv_cnt);
        end
    endtask

    task automatic test_sel_timing();
        btn[0] = 1'b1;
        repeat (7) tick();
        n_cmp++;
        if (EDITING !== 1'b0) begin
            n_fail++;
            $display("FAIL sel_early: got %b exp 0", EDITING);
        end
        tick();
        n_cmp++;
        if (EDITING !== 1'b1 || DP !== 4'b0001) begin
            n_fail++;
            $display("FAIL sel_latency: got ed=%b dp=%b exp ed=1 dp=0001",
                     EDITING, DP);
        end
        repeat (2) tick();
        btn[0] = 1'b0;
        repeat (10) tick();
        apply(0);
        repeat (3) press(1, 8, 10);
        n_cmp++;
        if (Z !== 4'd3 || Z !== 4'(m_dig[0])) begin
            n_fail++;
            $display("FAIL inc3: got Z=%0d exp 3", Z);
        end
        press(0, 8, 10);
        press(2, 8, 10);
        n_cmp++;
        if (Y !== 4'd9 || DP !== 4'b0010 || {W, X, Y, Z} !== m_val()) begin
            n_fail++;
            $display("FAIL dec_wrap: got val=%h dp=%b exp Y=9 dp=0010",
                     {W, X, Y, Z}, DP);
        end
    endtask

    task automatic test_inc_wrap();
        while (m_sel != 0) press(0, 8, 10);
        while (m_dig[0] != 0) press(1, 8, 10);
        for (int i = 1; i <= 10; i++) begin
            press(1, 7, 9);
            n_cmp++;
            if (Z !== 4'(i % 10)) begin
                n_fail++;
                $display("FAIL inc_seq %0d: got %0d exp %0d", i, Z, i % 10);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            press(0, 6, 9);
            n_cmp++;
            if (DP !== 4'(1 << (k % 4))) begin
                n_fail++;
                $display("FAIL sel_wrap %0d: got %b exp %b", k, DP,
                         4'(1 << (k % 4)));
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 6; i++) begin
            btn[1] = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            btn[1] = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        btn[1] = 1'b1;
        repeat (8) tick();
        btn[1] = 1'b0;
        repeat (10) tick();
        apply(1);
        n_cmp++;
        if ({W, X, Y, Z} !== m_val()) begin
            n_fail++;
            $display("FAIL bounce_once: got %h exp %h", {W, X, Y, Z}, m_val());
        end
        CE = 1'b0;
        press(1, 8, 10);
        CE = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if ({W, X, Y, Z} !== m_val() || EDITING !== 1'b1) begin
            n_fail++;
            $display("FAIL ce_low: got %h ed=%b exp %h ed=1",
                     {W, X, Y, Z}, EDITING, m_val());
        end
    endtask

    task automatic test_load_value();
        int lv0;
        if (!m_edit) press(0, 8, 10);
        while (m_sel != 0) press(0, 8, 10);
        for (int p = 0; p < 4; p++) begin
            while (m_dig[p] != 4 - p) press(1, 6, 9);
            if (p < 3) press(0, 6, 9);
        end
        lv0 = lv_cnt;
        btn[3] = 1'b1;
        repeat (8) tick();
        n_cmp++;
        if (LOAD_VALID !== 1'b1 || {W, X, Y, Z} !== 16'h1234) begin
            n_fail++;
            $display("FAIL load_strobe: got lv=%b val=%h exp lv=1 val=1234",
                     LOAD_VALID, {W, X, Y, Z});
        end
        tick();
        n_cmp++;
        if (LOAD_VALID !== 1'b0 || EDITING !== 1'b0 || DP !== 4'b0000) begin
            n_fail++;
            $display("FAIL load_after: got lv=%b ed=%b dp=%b exp 0 0 0000",
                     LOAD_VALID, EDITING, DP);
        end
        btn[3] = 1'b0;
        repeat (10) tick();
        apply(3);
        n_cmp++;
        if (lv_cnt !== lv0 + 1 || lv_val !== 16'h1234) begin
            n_fail++;
            $display("FAIL load_once: got n=%0d val=%h exp n=%0d val=1234",
                     lv_cnt - lv0, lv_val, 1);
        end
    endtask

    task automatic test_same_cycle();
        int lv0;
        press(0, 8, 10);
        lv0 = lv_cnt;
        btn[3] = 1'b1;
        btn[1] = 1'b1;
        repeat (8) tick();
        btn = 4'b0000;
        repeat (10) tick();
        apply(3);
        n_cmp++;
        if (lv_cnt !== lv0 + 1 || {W, X, Y, Z} !== m_val() ||
            EDITING !== 1'b0) begin
            n_fail++;
            $display("FAIL load_beats_inc: got n=%0d val=%h ed=%b exp 1 %h 0",
                     lv_cnt - lv0, {W, X, Y, Z}, EDITING, m_val());
        end
    endtask

    task automatic test_blink(input int b);
        logic [3:0] exp_b;
        btn[b] = 1'b1;
        repeat (8) tick();
        apply(b);
        for (int k = 0; k < 36; k++) begin
            if (k == 2) btn[b] = 1'b0;
            exp_b = ((k / 8) % 2 == 1) ? 4'(1 << m_sel) : 4'b0000;
            n_cmp++;
            if (BLANK !== exp_b) begin
                n_fail++;
                $display("FAIL blink b%0d k%0d: got %b exp %b", b, k,
                         BLANK, exp_b);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int r, b, lv0;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            b = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            CE = ($urandom_range(0, 7) != 0);
            lv0 = lv_cnt;
            press(b, $urandom_range(6, 10), $urandom_range(8, 12));
            n_cmp++;
            if ({W, X, Y, Z} !== m_val() || EDITING !== m_edit ||
                DP !== m_dp() ||
                lv_cnt !== lv0 + ((b == 3 && CE) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL rand %0d b%0d ce%b: got %h ed=%b dp=%b exp %h ed=%b dp=%b",
                         i, b, CE, {W, X, Y, Z}, EDITING, DP,
                         m_val(), m_edit, m_dp());
            end
        end
        CE = 1'b1;
    endtask

    task automatic test_reset_mid_edit();
        if (!m_edit) press(0, 8, 10);
        press(1, 8, 10);
        R = 1'b1;
        tick();
        n_cmp++;
        if ({W, X, Y, Z, DP, BLANK, LOAD_VALID, EDITING} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_mid_edit: got %h exp 0",
                     {W, X, Y, Z, DP, BLANK, LOAD_VALID, EDITING});
        end
        R = 1'b0;
        m_reset();
        repeat (10) tick();
        n_cmp++;
        if ({W, X, Y, Z, DP, EDITING} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h exp 0", {W, X, Y, Z, DP, EDITING});
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_sel_timing();
        test_inc_wrap();
        test_bounce();
        test_load_value();
        test_same_cycle();
        test_blink(0);
        test_blink(1);
        test_blink(0);
        test_blink(2);
        test_random();
        test_reset_mid_edit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_entry.md
Name: digit_entry

Overview:
- User-input counterpart to the four-digit seven-segment display path: reads four raw pushbuttons and lets the user compose a four-digit BCD value (W X Y Z).
- Presents that value to the display and to the counter chain.
- Outputs drive fourDigitDisplay's digit, decimal-point and blanking inputs.
- Issues a one-cycle LOAD_VALID strobe so the mod-10 counters can preload the entered value.

Parameters:
- DB_CYCLES, 250000, consecutive stable cycles required to accept a button level change (5 ms at 50 MHz).
- BLINK_CYCLES, 12500000, half-period in cycles of the selected-digit blink.

Ports:
- CLK  input  1  system clock
- R  input  1  reset; synchronous, active-high
- CE  input  1  enable; when low, all button presses are ignored
- BTN_SEL  input  1  raw, asynchronous: enter edit / advance digit
- BTN_INC  input  1  raw: increment selected digit
- BTN_DEC  input  1  raw: decrement selected digit
- BTN_LOAD  input  1  raw: commit value
- W  output  4  BCD digit 3 (leftmost)
- X  output  4  BCD digit 2
- Y  output  4  BCD digit 1
- Z  output  4  BCD digit 0 (rightmost)
- DP  output  4  decimal points; one-hot selected digit while editing
- BLANK  output  4  per-digit blank; selected digit blinks while editing
- LOAD_VALID  output  1  one-cycle strobe; W..Z valid in the same cycle
- EDITING  output  1  high while in EDIT state

Behaviour:
- Reset (R=1 at a CLK edge) overrides everything and sets:
  - W=X=Y=Z=0, DP=0, BLANK=0, LOAD_VALID=0, EDITING=0.
  - State IDLE, sel=0, blink counter and phase 0.
  - All debounce levels, counters and synchronisers 0.
- Per-button conditioning:
  - 2-FF synchroniser, then debounce counter.
  - The counter increments while the synchronised level differs from the debounced level and clears when they match.
  - When it reaches DB_CYCLES, the debounced level flips and the counter clears.
  - A rising edge of the debounced level produces a one-cycle press pulse.
  - The press pulse asserts DB_CYCLES+3 cycles after a clean raw rising edge.
  - Releases produce no pulse. Bounces shorter than DB_CYCLES are rejected.
- Press pulses are consumed only when CE=1. Debouncers run regardless of CE.
- Same-cycle pulses have priority LOAD > SEL > INC > DEC; lower-priority pulses that cycle are discarded.
- State machine (registered outputs update on the cycle after the press pulse):
  - IDLE:
    - SEL → EDIT with sel=0 (Z).
    - LOAD → COMMIT (re-issues current value).
    - INC/DEC ignored.
  - EDIT:
    - SEL → sel=(sel+1) mod 4 (3 wraps to 0).
    - INC → digit[sel] = 9 ? 0 : +1.
    - DEC → digit[sel] = 0 ? 9 : −1.
    - LOAD → COMMIT.
  - COMMIT:
    - LOAD_VALID=1 for exactly one cycle.
    - Next state IDLE; sel cleared to 0.
- Digits are always legal BCD (0–9); no value above 9 is ever output.
- EDITING=1 only in EDIT.
- DP=(1<<sel) in EDIT, else 0.
- Blink:
  - The counter runs only in EDIT. The phase toggles every BLINK_CYCLES cycles.
  - BLANK=(phase ? 1<<sel : 0).
  - Entering EDIT, or any SEL/INC/DEC press, clears the counter and phase, so the edited digit is shown immediately.
  - BLANK=0 outside EDIT.
- CE dropping mid-EDIT: state, digits and blink are held. Only press consumption stops.

Decomposition:
- Shared package holds:
  - State encodings IDLE/EDIT/COMMIT.
  - BCD_MAX=9.
  - DIGITS=4.
  - Priority order constants.
- One natural sub-module: button_debounce (sync + debounce + rising-edge pulse, parameter DB_CYCLES), instantiated four times.
- FSM, digit registers and blink logic stay in digit_entry.

Test Plan:
All scenarios use DB_CYCLES=4, BLINK_CYCLES=8.
1. Reset then idle 50 cycles → W..Z=0, DP=0, BLANK=0, LOAD_VALID never asserted.
2. Clean SEL press → EDITING=1 and DP=4'b0001 exactly 8 cycles after the raw edge. Then INC ×3 → Z=3. Then SEL ×1, DEC ×1 → Y=9 (wrap), DP=4'b0010.
3. INC ×10 on digit 0 → Z sequence 1..9,0. SEL ×4 from sel=0 → DP=4'b0001 again (wrap).
4. BTN_INC bouncing with 1–3-cycle pulses, then stable high ≥4 cycles → exactly one increment. CE=0 during a clean INC press → no change.
5. Enter value 1,2,3,4 (W..Z), press LOAD → LOAD_VALID high exactly 1 cycle with W=1 X=2 Y=3 Z=4; EDITING=0 and DP=0 next cycle.
6. LOAD and INC debounced in the same cycle → commit only, digit unchanged. In EDIT, BLANK toggles bit sel every 8 cycles. R asserted mid-EDIT → all outputs 0 on the next edge.
